// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register busy scoreboard, issue/stall decision, control bubbles and halt drain
// Optional build macro WB_BYPASS_EN: a same-cycle writeback hides the busy bit from the hazard check.
module hazard_scoreboard #(
   parameter int NUM_REGS     = 16,
   parameter int CTRL_BUBBLES = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [3:0]          id_opcode,
   input  logic [3:0]          id_dst,
   input  logic [3:0]          id_src_a,
   input  logic [3:0]          id_src_b,
   input  logic                wb_valid,
   input  logic [3:0]          wb_rd,
   output logic                issue,
   output logic                stall,
   output logic                flush,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                halted,
   output logic [1:0]          fsm_state
);

   localparam logic [3:0] OP_HALT = 4'b0000;
   localparam logic [3:0] OP_R    = 4'b0001;
   localparam logic [3:0] OP_I    = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_J    = 4'b0100;
   localparam logic [3:0] OP_BR   = 4'b1000;
   localparam logic [3:0] OP_LD   = 4'b1100;

   localparam logic [2:0] BUB_INIT = 3'(CTRL_BUBBLES - 1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FLUSH = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t              r_state;
   logic [NUM_REGS-1:0] r_busy;
   logic [2:0]          r_cnt;
   logic                r_flush;
   logic                r_halted;

   logic                w_use_a;
   logic                w_use_b;
   logic                w_writes;
   logic                w_ctrl;
   logic                w_halt_op;
   logic                w_run;
   logic                w_hazard;
   logic                w_issue;
   logic [NUM_REGS-1:0] w_clr_mask;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_busy_eff;
   logic [NUM_REGS-1:0] w_busy_next;

   always_comb begin
      w_use_a   = (id_opcode == OP_R) || (id_opcode == OP_BR) ||
                  (id_opcode == OP_I) || (id_opcode == OP_ST);
      w_use_b   = (id_opcode == OP_R) || (id_opcode == OP_BR);
      w_writes  = (id_opcode == OP_R) || (id_opcode == OP_I) || (id_opcode == OP_LD);
      w_ctrl    = (id_opcode == OP_J) || (id_opcode == OP_BR);
      w_halt_op = (id_opcode == OP_HALT);
   end

   always_comb begin
      w_clr_mask = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_clr_mask[i] = wb_valid && (wb_rd == 4'(i));
      end
   end

`ifdef WB_BYPASS_EN
   assign w_busy_eff = r_busy & ~w_clr_mask;
`else
   assign w_busy_eff = r_busy;
`endif

   assign w_hazard = (w_use_a && w_busy_eff[id_src_a]) || (w_use_b && w_busy_eff[id_src_b]);
   // Nothing may issue while reset is held, even though the state already reads RUN.
   assign w_run    = (r_state == S_RUN) && !rst;
   assign w_issue  = id_valid && w_run && !w_hazard;

   always_comb begin
      w_set_mask = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_set_mask[i] = w_issue && w_writes && (id_dst == 4'(i));
      end
   end

   // Set is OR-ed after the clear so a same-cycle writer keeps its bit.
   assign w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_RUN;
         r_busy   <= '0;
         r_cnt    <= 3'd0;
         r_flush  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_busy <= w_busy_next;
         case (r_state)
            S_RUN: begin
               if (w_issue && w_ctrl) begin
                  r_state <= S_FLUSH;
                  r_cnt   <= BUB_INIT;
                  r_flush <= 1'b1;
               end else if (w_issue && w_halt_op) begin
                  r_state <= S_DRAIN;
               end
            end
            S_FLUSH: begin
               if (r_cnt == 3'd0) begin
                  r_state <= S_RUN;
                  r_flush <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_DRAIN: begin
               if (w_busy_next == '0) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end
            end
            S_HALT: begin
               r_halted <= 1'b1;
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign issue     = w_issue;
   assign stall     = id_valid && w_run && w_hazard;
   assign flush     = r_flush;
   assign busy_vec  = r_busy;
   assign halted    = r_halted;
   assign fsm_state = r_state;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed-vector self-checking bench for hazard_scoreboard
// Expected values follow the WB_BYPASS_EN build macro when it is defined.
module tb_hazard_scoreboard;

   localparam logic [3:0] OP_HALT = 4'b0000;
   localparam logic [3:0] OP_R    = 4'b0001;
   localparam logic [3:0] OP_I    = 4'b0010;
   localparam logic [3:0] OP_J    = 4'b0100;
   localparam logic [3:0] OP_BR   = 4'b1000;
   localparam logic [3:0] OP_LD   = 4'b1100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [3:0]  id_opcode = 4'd0;
   logic [3:0]  id_dst = 4'd0;
   logic [3:0]  id_src_a = 4'd0;
   logic [3:0]  id_src_b = 4'd0;
   logic        wb_valid = 1'b0;
   logic [3:0]  wb_rd = 4'd0;
   logic        issue;
   logic        stall;
   logic        flush;
   logic [15:0] busy_vec;
   logic        halted;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_scoreboard #(.NUM_REGS(16), .CTRL_BUBBLES(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .id_valid  (id_valid),
      .id_opcode (id_opcode),
      .id_dst    (id_dst),
      .id_src_a  (id_src_a),
      .id_src_b  (id_src_b),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .issue     (issue),
      .stall     (stall),
      .flush     (flush),
      .busy_vec  (busy_vec),
      .halted    (halted),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [3:0] op, input logic [3:0] dst,
                           input logic [3:0] a, input logic [3:0] b);
      id_valid  = v;
      id_opcode = op;
      id_dst    = dst;
      id_src_a  = a;
      id_src_b  = b;
      #1;
   endtask

   task automatic drive_wb(input logic v, input logic [3:0] rd);
      wb_valid = v;
      wb_rd    = rd;
      #1;
   endtask

   initial begin
      // Reset state, with an instruction presented during reset
      drive_id(1'b1, OP_R, 4'd3, 4'd1, 4'd2);
      tick();
      expect_eq("rst_busy", busy_vec, 32'h0);
      expect_eq("rst_flush", flush, 0);
      expect_eq("rst_halted", halted, 0);
      expect_eq("rst_state", fsm_state, 0);
      expect_eq("rst_issue", issue, 0);
      expect_eq("rst_stall", stall, 0);
      rst = 1'b0;
      #1;

      // R-type on empty scoreboard
      expect_eq("r_issue", issue, 1);
      expect_eq("r_stall", stall, 0);
      tick();
      drive_id(1'b0, OP_R, 4'd0, 4'd0, 4'd0);
      expect_eq("r_busy", busy_vec, 32'h0008);

      // RAW hazard on reg 3
      drive_id(1'b1, OP_I, 4'd4, 4'd3, 4'd0);
      expect_eq("raw_stall0", stall, 1);
      expect_eq("raw_issue0", issue, 0);
      tick();
      expect_eq("raw_stall1", stall, 1);
      expect_eq("raw_busy_hold", busy_vec, 32'h0008);
      drive_wb(1'b1, 4'd3);
`ifdef WB_BYPASS_EN
      expect_eq("wb_cycle_issue", issue, 1);
      tick();
      drive_wb(1'b0, 4'd0);
      drive_id(1'b0, OP_R, 4'd0, 4'd0, 4'd0);
      expect_eq("bypass_busy", busy_vec, 32'h0010);
`else
      expect_eq("wb_cycle_issue", issue, 0);
      expect_eq("wb_cycle_stall", stall, 1);
      tick();
      drive_wb(1'b0, 4'd0);
      expect_eq("wb_clr_busy", busy_vec, 32'h0000);
      expect_eq("post_wb_issue", issue, 1);
      tick();
      drive_id(1'b0, OP_R, 4'd0, 4'd0, 4'd0);
      expect_eq("post_wb_busy", busy_vec, 32'h0010);
`endif

      // LD reg 5, then same-cycle LD reg 5 with writeback reg 5
      drive_id(1'b1, OP_LD, 4'd5, 4'd4, 4'd4);
      expect_eq("ld_issue", issue, 1);
      tick();
      expect_eq("ld_busy", busy_vec, 32'h0030);
      drive_wb(1'b1, 4'd5);
      expect_eq("ld_wb_issue", issue, 1);
      tick();
      drive_id(1'b0, OP_R, 4'd0, 4'd0, 4'd0);
      expect_eq("set_wins_busy", busy_vec, 32'h0030);

      // Writeback to an idle register changes nothing
      drive_wb(1'b1, 4'd9);
      tick();
      drive_wb(1'b0, 4'd0);
      expect_eq("idle_wb_busy", busy_vec, 32'h0030);

      // BR reads both sources; src_b=5 is busy
      drive_id(1'b1, OP_BR, 4'd0, 4'd7, 4'd5);
      expect_eq("br_stall", stall, 1);
      expect_eq("br_issue", issue, 0);

      // J: three flush cycles, decode ignored
      drive_id(1'b1, OP_J, 4'd0, 4'd5, 4'd5);
      expect_eq("j_issue", issue, 1);
      tick();
      drive_id(1'b1, OP_R, 4'd7, 4'd0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         expect_eq($sformatf("flush_hi%0d", i), flush, 1);
         expect_eq($sformatf("flush_state%0d", i), fsm_state, 1);
         expect_eq($sformatf("flush_issue%0d", i), issue, 0);
         expect_eq($sformatf("flush_stall%0d", i), stall, 0);
         tick();
      end
      expect_eq("flush_done", flush, 0);
      expect_eq("flush_run", fsm_state, 0);
      expect_eq("flush_busy", busy_vec, 32'h0030);
      drive_id(1'b0, OP_R, 4'd0, 4'd0, 4'd0);

      // HALT with regs 4,5 pending
      drive_id(1'b1, OP_HALT, 4'd0, 4'd0, 4'd0);
      expect_eq("halt_issue", issue, 1);
      tick();
      drive_id(1'b0, OP_R, 4'd0, 4'd0, 4'd0);
      expect_eq("drain_state", fsm_state, 2);
      expect_eq("drain_halted", halted, 0);
      drive_wb(1'b1, 4'd4);
      tick();
      expect_eq("drain_busy1", busy_vec, 32'h0020);
      expect_eq("drain_state1", fsm_state, 2);
      drive_wb(1'b1, 4'd5);
      tick();
      drive_wb(1'b0, 4'd0);
      expect_eq("drain_busy0", busy_vec, 32'h0000);
      expect_eq("halt_state", fsm_state, 3);
      expect_eq("halt_flag", halted, 1);
      drive_id(1'b1, OP_R, 4'd1, 4'd0, 4'd0);
      expect_eq("halt_no_issue", issue, 0);
      expect_eq("halt_no_stall", stall, 0);
      tick();
      expect_eq("halt_sticky", halted, 1);
      expect_eq("halt_busy_held", busy_vec, 32'h0000);
      drive_id(1'b0, OP_R, 4'd0, 4'd0, 4'd0);

      // Reset pulse leaves HALT
      rst = 1'b1;
      #1;
      expect_eq("rst_halt_flag", halted, 0);
      expect_eq("rst_halt_state", fsm_state, 0);
      tick();
      rst = 1'b0;
      #1;

      // HALT on empty scoreboard: one DRAIN cycle
      drive_id(1'b1, OP_HALT, 4'd0, 4'd0, 4'd0);
      tick();
      drive_id(1'b0, OP_R, 4'd0, 4'd0, 4'd0);
      expect_eq("empty_drain", fsm_state, 2);
      tick();
      expect_eq("empty_halt", fsm_state, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;

      // Fill regs 8..11, then reset asynchronously mid-FLUSH
      for (int r = 8; r < 12; r++) begin
         drive_id(1'b1, OP_R, 4'(r), 4'd0, 4'd0);
         tick();
      end
      drive_id(1'b1, OP_J, 4'd0, 4'd0, 4'd0);
      tick();
      drive_id(1'b0, OP_R, 4'd0, 4'd0, 4'd0);
      expect_eq("pre_rst_busy", busy_vec, 32'h0F00);
      expect_eq("pre_rst_flush", flush, 1);
      tick();
      rst = 1'b1;
      #1;
      expect_eq("async_busy", busy_vec, 32'h0000);
      expect_eq("async_flush", flush, 0);
      expect_eq("async_state", fsm_state, 0);
      tick();
      rst = 1'b0;
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Central register-hazard and control-flow scheduler for the 4-stage pipeline. It owns the 16-entry register busy scoreboard and decides each cycle whether the decoded instruction may issue or must stall. It inserts bubbles after jumps and branches, and sequences program halt by draining outstanding writes. It sits between decode (requester) and the register file/writeback (resource owner) and replaces ad-hoc availability bookkeeping.

Parameters:
NUM_REGS, 16, number of architectural registers tracked (address width fixed at 4)
CTRL_BUBBLES, 3, bubble cycles inserted after an issued jump (0100) or branch (1000); legal range 1..7

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous active-high reset
id_valid  input  1  decode presents an instruction this cycle
id_opcode  input  4  decoded opcode (0001 R, 0010 I, 1000 BR, 0100 J, 1100 LD, 0011 ST, 0000 HALT)
id_dst  input  4  destination register (R: rd; I/LD: rs)
id_src_a  input  4  first source (R: rs; I: rt; BR: rs; ST: rs)
id_src_b  input  4  second source (R: rt; BR: rt)
wb_valid  input  1  writeback retires a register write this cycle
wb_rd  input  4  register being written back
issue  output  1  combinational; instruction accepted this cycle
stall  output  1  combinational; id_valid and not issue in RUN (decode holds PC)
flush  output  1  registered; high while in FLUSH state
busy_vec  output  16  registered scoreboard, bit n = register n has pending write
halted  output  1  registered; program complete
fsm_state  output  2  RUN=0, FLUSH=1, DRAIN=2, HALT=3

Behaviour:
- Reset (async, rst=1): busy_vec=0, state RUN, flush=0, halted=0, bubble counter=0. issue=stall=0 while rst asserted.
- Source usage: R and BR use src_a and src_b; I and ST use src_a only; LD, J, and HALT use no sources.
- Destination usage: R, I, and LD write id_dst; BR, ST, J, and HALT write nothing.
- Hazard: any used source whose busy bit is set (subject to WB_BYPASS_EN). WAW does not stall. A new writer simply keeps the bit set.
- issue = id_valid & state==RUN & !hazard. stall = id_valid & state==RUN & hazard. In FLUSH, DRAIN, and HALT: issue=0, stall=0. Decode must discard its instruction during flush.
- Scoreboard update at clk edge: if wb_valid, clear busy[wb_rd]. If issue and the opcode writes, set busy[id_dst]. When the set and clear target the same register in the same cycle, the set wins.
- wb_valid on a register that is not busy is a no-op.
- FSM:
  - RUN: issue of J or BR -> FLUSH, counter=CTRL_BUBBLES-1. Issue of HALT -> DRAIN.
  - FLUSH: counter decrements each cycle. At 0 -> RUN. flush is high for exactly CTRL_BUBBLES cycles starting the cycle after issue.
  - DRAIN: stays while busy_vec (post-update) != 0. When it is 0 -> HALT. If busy_vec is already 0 at HALT issue, DRAIN lasts 1 cycle.
  - HALT: halted=1, sticky until rst.
- Writebacks continue to clear bits in every state, including FLUSH, DRAIN, and HALT.
- Reset mid-FLUSH or mid-DRAIN returns to RUN with an empty scoreboard on the same edge (async).
- Latency: a dependent instruction stalls until the cycle after the clearing writeback edge (no bypass build).

Optional Feature:
WB_BYPASS_EN: when defined, a source matching wb_rd with wb_valid=1 is treated as not busy in the same cycle. The dependent instruction issues in the writeback cycle, saving one stall cycle. When undefined, hazard uses only registered busy_vec. Scoreboard update rules are identical in both builds.

Test Plan:
- Reset then R-type rd=3, rs=1, rt=2 with empty scoreboard -> issue=1, stall=0; next cycle busy_vec=16'h0008.
- busy[3] set, I-type src_a=3 -> stall=1 each cycle. wb_valid with wb_rd=3 -> without WB_BYPASS_EN issue=1 on the following cycle; with it, issue=1 in the same cycle.
- Issue J with CTRL_BUBBLES=3 -> flush=1 for exactly 3 cycles, fsm_state=1 during them, id_valid ignored; RUN (0) on the 4th cycle.
- Same-cycle issue of LD dst=5 and wb_valid wb_rd=5 while busy[5]=1 -> busy[5] remains 1.
- HALT issued while busy_vec=16'h0030 -> DRAIN. Writebacks to regs 4 and 5 -> busy_vec=0, then halted=1 and fsm_state=3 one cycle later. rst pulse -> halted=0, RUN.
- Assert rst mid-FLUSH with busy_vec=16'h0F00 -> immediate (asynchronous) busy_vec=0, flush=0, fsm_state=0.
